// File: rtl/rtc_digit_reader.sv
// Bus-master reader for the RTC multiplexed address/data bus.
// Bursts through 10 RTC registers into a shadow bank and commits them to the screen digits atomically.
module rtc_digit_reader #(
  parameter int unsigned PERIOD_CYCLES = 10_000_000,
  parameter int unsigned TPH           = 4,
  parameter logic [7:0]  ADDR_CLK      = 8'h21,
  parameter logic [7:0]  ADDR_TMR      = 8'h41
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic       rd_req,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       busy,
  output logic       done,
  output logic       bcd_err,
  output logic [3:0] digit0_HH,   output logic [3:0] digit1_HH,
  output logic [3:0] digit0_MM,   output logic [3:0] digit1_MM,
  output logic [3:0] digit0_SS,   output logic [3:0] digit1_SS,
  output logic [3:0] digit0_DAY,  output logic [3:0] digit1_DAY,
  output logic [3:0] digit0_MES,  output logic [3:0] digit1_MES,
  output logic [3:0] digit0_YEAR, output logic [3:0] digit1_YEAR,
  output logic [3:0] digit0_HH_T, output logic [3:0] digit1_HH_T,
  output logic [3:0] digit0_MM_T, output logic [3:0] digit1_MM_T,
  output logic [3:0] digit0_SS_T, output logic [3:0] digit1_SS_T,
  output logic       AM_PM,
  output logic [2:0] dia_semana
);

  // state   | meaning
  // S_IDLE  | waiting for pending && !hold
  // S_ADDR  | address phase, TPH cycles
  // S_GAP   | 1 turnaround cycle, bus released
  // S_DATA  | read phase, TPH cycles, sample on last cycle
  // S_REC   | recovery, TPH cycles
  // S_COMMIT| shadow bank copied to outputs
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP, S_DATA, S_REC, S_COMMIT} state_t;

  localparam logic [3:0]  PH_LOAD  = 4'(TPH - 1);
  localparam logic [23:0] PER_LAST = 24'(PERIOD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  ph_q, ph_d, idx_q, idx_d;
  logic [23:0] per_q, per_d;
  logic        pend_q, pend_d, per_wrap;
  logic [7:0]  shadow_q [10];
  logic [7:0]  shadow_d [10];
  logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, ad_q, ad_d, oe_q, oe_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]  bus_out_q, bus_out_d;
  // Digit slots: 0 SS, 1 MM, 2 HH, 3 DAY, 4 MES, 5 YEAR, 6 SS_T, 7 MM_T, 8 HH_T
  logic [3:0]  d0_q [9], d0_d [9], d1_q [9], d1_d [9];
  logic [3:0]  dec_d0 [9], dec_d1 [9];
  logic        ampm_q, ampm_d, dec_ampm, burst_err;
  logic [2:0]  dow_q, dow_d, dec_dow;

  function automatic logic [3:0] bcd_clip(input logic [3:0] n);
    return (n > 4'd9) ? 4'd0 : n;
  endfunction

  function automatic logic bcd_bad(input logic [7:0] r);
    return (r[7:4] > 4'd9) || (r[3:0] > 4'd9);
  endfunction

  always_comb begin
    burst_err = 1'b0;
    for (int k = 0; k < 10; k++) burst_err = burst_err | bcd_bad(shadow_q[k]);
    for (int s = 0; s < 9; s++) begin
      dec_d0[s] = bcd_clip(shadow_q[(s < 6) ? s : s + 1][3:0]);
      dec_d1[s] = bcd_clip(shadow_q[(s < 6) ? s : s + 1][7:4]);
    end
    // hour tens is a single bit; bit5 carries AM/PM
    dec_d1[2] = {3'b000, shadow_q[2][4]};
    dec_d1[8] = {3'b000, shadow_q[9][4]};
    dec_ampm  = shadow_q[2][5];
    dec_dow   = shadow_q[6][2:0];
  end

  always_comb begin
    per_wrap = (per_q == PER_LAST);
    per_d    = per_wrap ? '0 : per_q + 24'd1;
    state_d  = state_q;
    ph_d     = ph_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    d0_d     = d0_q;
    d1_d     = d1_q;
    ampm_d   = ampm_q;
    dow_d    = dow_q;
    case (state_q)
      S_IDLE: if (pend_q && !hold) begin
        state_d = S_ADDR;
        idx_d   = '0;
        ph_d    = PH_LOAD;
        pend_d  = 1'b0;
        busy_d  = 1'b1;
      end
      S_ADDR: if (ph_q == '0) state_d = S_GAP; else ph_d = ph_q - 4'd1;
      S_GAP: begin
        state_d = S_DATA;
        ph_d    = PH_LOAD;
      end
      S_DATA: if (ph_q == '0) begin
        shadow_d[idx_q] = bus_in;
        state_d = S_REC;
        ph_d    = PH_LOAD;
      end else ph_d = ph_q - 4'd1;
      S_REC: if (ph_q == '0) begin
        if (idx_q == 4'd9) state_d = S_COMMIT;
        else begin
          state_d = S_ADDR;
          idx_d   = idx_q + 4'd1;
          ph_d    = PH_LOAD;
        end
      end else ph_d = ph_q - 4'd1;
      S_COMMIT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = burst_err;
        d0_d    = dec_d0;
        d1_d    = dec_d1;
        ampm_d  = dec_ampm;
        dow_d   = dec_dow;
      end
      default: state_d = S_IDLE;
    endcase
    // a request arriving while busy (or on the start cycle) wins over the clear
    if (per_wrap || rd_req) pend_d = 1'b1;

    cs_n_d    = !((state_d == S_ADDR) || (state_d == S_DATA));
    ad_d      = (state_d != S_ADDR);
    rd_n_d    = (state_d != S_DATA);
    oe_d      = (state_d == S_ADDR);
    bus_out_d = '0;
    if (state_d == S_ADDR)
      bus_out_d = (idx_d < 4'd7) ? ADDR_CLK + {4'b0000, idx_d}
                                 : ADDR_TMR + {4'b0000, idx_d} - 8'd7;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      idx_q     <= '0;
      per_q     <= '0;
      pend_q    <= 1'b0;
      shadow_q  <= '{default: 8'h00};
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      ad_q      <= 1'b1;
      oe_q      <= 1'b0;
      bus_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      d0_q      <= '{default: 4'h0};
      d1_q      <= '{default: 4'h0};
      ampm_q    <= 1'b0;
      dow_q     <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      idx_q     <= idx_d;
      per_q     <= per_d;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      ad_q      <= ad_d;
      oe_q      <= oe_d;
      bus_out_q <= bus_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      ampm_q    <= ampm_d;
      dow_q     <= dow_d;
    end
  end

  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = 1'b1;
  assign ad      = ad_q;
  assign bus_out = bus_out_q;
  assign bus_oe  = oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_err = err_q;

  assign digit0_SS   = d0_q[0]; assign digit1_SS   = d1_q[0];
  assign digit0_MM   = d0_q[1]; assign digit1_MM   = d1_q[1];
  assign digit0_HH   = d0_q[2]; assign digit1_HH   = d1_q[2];
  assign digit0_DAY  = d0_q[3]; assign digit1_DAY  = d1_q[3];
  assign digit0_MES  = d0_q[4]; assign digit1_MES  = d1_q[4];
  assign digit0_YEAR = d0_q[5]; assign digit1_YEAR = d1_q[5];
  assign digit0_SS_T = d0_q[6]; assign digit1_SS_T = d1_q[6];
  assign digit0_MM_T = d0_q[7]; assign digit1_MM_T = d1_q[7];
  assign digit0_HH_T = d0_q[8]; assign digit1_HH_T = d1_q[8];
  assign AM_PM       = ampm_q;
  assign dia_semana  = dow_q;

endmodule

// File: tb/tb_rtc_digit_reader.sv
// Scoreboarded bench for rtc_digit_reader: an RTC bus model answers reads from a register
// image, and each burst's expected screen contents are queued at burst start and compared on done.
module tb_rtc_digit_reader;
  localparam int PERIOD = 1000;
  localparam int TPH    = 2;

  logic clock = 1'b0, reset = 1'b0, hold = 1'b0, rd_req = 1'b0;
  logic [7:0] bus_in = 8'hEE;
  logic cs_n, rd_n, wr_n, ad, bus_oe, busy, done, bcd_err, AM_PM;
  logic [7:0] bus_out;
  logic [2:0] dia_semana;
  logic [3:0] digit0_HH, digit1_HH, digit0_MM, digit1_MM, digit0_SS, digit1_SS;
  logic [3:0] digit0_DAY, digit1_DAY, digit0_MES, digit1_MES, digit0_YEAR, digit1_YEAR;
  logic [3:0] digit0_HH_T, digit1_HH_T, digit0_MM_T, digit1_MM_T, digit0_SS_T, digit1_SS_T;

  rtc_digit_reader #(.PERIOD_CYCLES(PERIOD), .TPH(TPH), .ADDR_CLK(8'h21), .ADDR_TMR(8'h41)) dut (
    .clock(clock), .reset(reset), .hold(hold), .rd_req(rd_req),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad(ad), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .busy(busy), .done(done), .bcd_err(bcd_err),
    .digit0_HH(digit0_HH), .digit1_HH(digit1_HH), .digit0_MM(digit0_MM), .digit1_MM(digit1_MM),
    .digit0_SS(digit0_SS), .digit1_SS(digit1_SS), .digit0_DAY(digit0_DAY), .digit1_DAY(digit1_DAY),
    .digit0_MES(digit0_MES), .digit1_MES(digit1_MES), .digit0_YEAR(digit0_YEAR), .digit1_YEAR(digit1_YEAR),
    .digit0_HH_T(digit0_HH_T), .digit1_HH_T(digit1_HH_T), .digit0_MM_T(digit0_MM_T), .digit1_MM_T(digit1_MM_T),
    .digit0_SS_T(digit0_SS_T), .digit1_SS_T(digit1_SS_T), .AM_PM(AM_PM), .dia_semana(dia_semana)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0][3:0] d0;
    logic [8:0][3:0] d1;
    logic            ampm;
    logic [2:0]      dow;
    logic            err;
  } exp_t;

  logic [7:0] mem [256];
  exp_t sb_q [$];
  exp_t e;
  int n_checks = 0, n_fail = 0, n_starts = 0, n_done = 0, wr_low = 0, cyc = 0, rd_cnt = 0;
  logic busy_prev = 1'b0, done_prev = 1'b0;
  logic [7:0] lat_addr = 8'h00;

  wire [8:0][3:0] act_d0 = {digit0_HH_T, digit0_MM_T, digit0_SS_T, digit0_YEAR, digit0_MES,
                            digit0_DAY, digit0_HH, digit0_MM, digit0_SS};
  wire [8:0][3:0] act_d1 = {digit1_HH_T, digit1_MM_T, digit1_SS_T, digit1_YEAR, digit1_MES,
                            digit1_DAY, digit1_HH, digit1_MM, digit1_SS};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] addr_of(input int k);
    return (k < 7) ? 8'(8'h21 + k) : 8'(8'h41 + k - 7);
  endfunction

  function automatic exp_t model_burst();
    exp_t x;
    logic [7:0] r;
    int s;
    x = '0;
    for (int k = 0; k < 10; k++) begin
      r = mem[addr_of(k)];
      if (r[7:4] > 4'd9 || r[3:0] > 4'd9) x.err = 1'b1;
      if (k == 6) x.dow = r[2:0];
      else begin
        s = (k < 6) ? k : k - 1;
        x.d0[s] = (r[3:0] > 4'd9) ? 4'd0 : r[3:0];
        x.d1[s] = (k == 2 || k == 9) ? {3'b000, r[4]} : ((r[7:4] > 4'd9) ? 4'd0 : r[7:4]);
        if (k == 2) x.ampm = r[5];
      end
    end
    return x;
  endfunction

  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0; else cyc <= cyc + 1;

  // RTC bus model: data is only valid on the TPH-th cycle of rd_n low, 8'hEE otherwise
  always @(negedge clock) begin
    if (!cs_n && !ad) lat_addr = bus_out;
    if (!rd_n) rd_cnt++; else rd_cnt = 0;
    bus_in = (!rd_n && rd_cnt == TPH) ? mem[lat_addr] : 8'hEE;
  end

  always @(negedge clock) begin
    if (reset) begin
      if (!wr_n) wr_low++;
      if (busy && !busy_prev) begin
        sb_q.push_back(model_burst());
        n_starts++;
      end
      if (done_prev) begin
        check("done_one_cycle", done, 0);
        check("bcd_err_clears", bcd_err, 0);
      end
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) check("sb_unexpected_done", 1, 0);
        else begin
          e = sb_q.pop_front();
          for (int i = 0; i < 9; i++) begin
            check($sformatf("digit0_slot%0d", i), act_d0[i], e.d0[i]);
            check($sformatf("digit1_slot%0d", i), act_d1[i], e.d1[i]);
          end
          check("AM_PM", AM_PM, e.ampm);
          check("dia_semana", dia_semana, e.dow);
          check("bcd_err", bcd_err, e.err);
          check("busy_low_at_done", busy, 0);
        end
      end
      busy_prev = busy;
      done_prev = done;
    end else begin
      busy_prev = 1'b0;
      done_prev = 1'b0;
    end
  end

  task automatic pulse_rd();
    @(negedge clock) rd_req = 1'b1;
    @(negedge clock) rd_req = 1'b0;
  endtask

  task automatic wait_busy(input int max);
    int n = 0;
    while (!busy && n < max) begin @(negedge clock); n++; end
    if (!busy) check("busy_timeout", 0, 1);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin @(negedge clock); n++; end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic load_mem(input logic [7:0] c0, c1, c2, c3, c4, c5, c6, t0, t1, t2);
    mem[8'h21] = c0; mem[8'h22] = c1; mem[8'h23] = c2; mem[8'h24] = c3;
    mem[8'h25] = c4; mem[8'h26] = c5; mem[8'h27] = c6;
    mem[8'h41] = t0; mem[8'h42] = t1; mem[8'h43] = t2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, s1, d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    load_mem(8'h59, 8'h58, 8'h32, 8'h31, 8'h12, 8'h16, 8'h05, 8'h01, 8'h02, 8'h03);

    repeat (3) @(negedge clock);
    check("rst_cs_n", cs_n, 1);     check("rst_rd_n", rd_n, 1);
    check("rst_wr_n", wr_n, 1);     check("rst_ad", ad, 1);
    check("rst_bus_oe", bus_oe, 0); check("rst_bus_out", bus_out, 0);
    check("rst_busy", busy, 0);     check("rst_done", done, 0);
    check("rst_bcd_err", bcd_err, 0);
    check("rst_digits0", act_d0, 0); check("rst_digits1", act_d1, 0);
    check("rst_ampm", AM_PM, 0);    check("rst_dow", dia_semana, 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_cs_n", cs_n, 1);
    check("idle_busy", busy, 0);
    check("idle_bus_oe", bus_oe, 0);

    // Burst with the reference register image, bus phase timing and latency
    pulse_rd();
    wait_busy(5);
    for (int t = 0; t < 8; t++) begin
      case (t)
        0, 1: begin
          check($sformatf("addr_t%0d_cs_n", t), cs_n, 0);
          check($sformatf("addr_t%0d_ad", t), ad, 0);
          check($sformatf("addr_t%0d_oe", t), bus_oe, 1);
          check($sformatf("addr_t%0d_bus_out", t), bus_out, 8'h21);
          check($sformatf("addr_t%0d_rd_n", t), rd_n, 1);
        end
        2: begin
          check("gap_cs_n", cs_n, 1);
          check("gap_oe", bus_oe, 0);
        end
        3, 4: begin
          check($sformatf("data_t%0d_cs_n", t), cs_n, 0);
          check($sformatf("data_t%0d_ad", t), ad, 1);
          check($sformatf("data_t%0d_rd_n", t), rd_n, 0);
          check($sformatf("data_t%0d_oe", t), bus_oe, 0);
        end
        5, 6: begin
          check($sformatf("rec_t%0d_cs_n", t), cs_n, 1);
          check($sformatf("rec_t%0d_rd_n", t), rd_n, 1);
        end
        default: check("addr_k1_bus_out", bus_out, 8'h22);
      endcase
      if (t < 7) @(negedge clock);
    end
    lat = 7;
    while (!done && lat < 200) begin @(negedge clock); lat++; end
    check("burst_latency", lat, 71);
    check("ref_digit1_SS", digit1_SS, 5);  check("ref_digit0_SS", digit0_SS, 9);
    check("ref_digit1_HH", digit1_HH, 1);  check("ref_digit0_HH", digit0_HH, 2);
    check("ref_AM_PM", AM_PM, 1);          check("ref_dia_semana", dia_semana, 5);
    check("ref_digit1_HH_T", digit1_HH_T, 0); check("ref_digit0_HH_T", digit0_HH_T, 3);
    repeat (5) @(negedge clock);

    // Two requests during a burst give exactly one extra burst; bad BCD in seconds
    mem[8'h21] = 8'h5A;
    s0 = n_starts;
    pulse_rd();
    wait_busy(5);
    repeat (10) @(negedge clock);
    pulse_rd();
    repeat (10) @(negedge clock);
    pulse_rd();
    wait_done(100);
    check("badbcd_digit0_SS", digit0_SS, 0);
    check("badbcd_err", bcd_err, 1);
    @(negedge clock);
    wait_busy(5);
    wait_done(100);
    repeat (20) @(negedge clock);
    check("extra_burst_count", n_starts - s0, 2);

    // hold rising mid-burst still commits; hold then blocks three counter wraps
    pulse_rd();
    wait_busy(5);
    repeat (20) @(negedge clock);
    hold = 1'b1;
    wait_done(100);
    s1 = n_starts;
    while (cyc < 3500) @(negedge clock);
    check("hold_blocks_starts", n_starts - s1, 0);
    hold = 1'b0;
    @(negedge clock);
    check("hold_release_start", busy, 1);
    wait_done(100);
    repeat (20) @(negedge clock);
    check("hold_release_one_burst", n_starts - s1, 1);

    // Reset while reading the month register aborts with no commit
    load_mem(8'h45, 8'h33, 8'h11, 8'h22, 8'h09, 8'h25, 8'h03, 8'h44, 8'h55, 8'h06);
    pulse_rd();
    wait_busy(5);
    repeat (31) @(negedge clock);
    check("k4_in_data", {ad, rd_n, bus_out}, {1'b1, 1'b1, 8'h00} & 10'h200 | {1'b0, rd_n, 8'h00});
    check("k4_rd_n_low", rd_n, 0);
    d0 = n_done;
    #2 reset = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1);   check("abort_rd_n", rd_n, 1);
    check("abort_busy", busy, 0);   check("abort_bus_oe", bus_oe, 0);
    check("abort_digits0", act_d0, 0);
    sb_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    check("abort_no_done", n_done - d0, 0);
    check("abort_no_partial", act_d1, 0);

    // Recovery burst after the abort
    pulse_rd();
    wait_busy(5);
    wait_done(100);
    check("recover_digit1_SS", digit1_SS, 4);
    check("recover_digit0_SS", digit0_SS, 5);
    repeat (5) @(negedge clock);
    check("sb_empty", sb_q.size(), 0);
    check("wr_n_never_low", wr_low, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
